dac_snapshot_capture: RTL and testbench
=======================================

Name: dac_snapshot_capture

Overview:
- Downstream debug stage on the DAC output path.
- Sits on one registered `dacN_data` bus of the receive core, same `clock` domain.
- Once armed and triggered, records a burst of consecutive multi-lane DAC words into on-chip RAM, then replays them over an AXI-Stream-style master port to the capture DMA.
- Used to inspect DUC output without stalling the datapath.

Parameters:
- NUMBER_OF_LINE, 8, number of 16-bit lanes per DAC word.
- DEPTH, 1024, buffer depth in words; must be a power of two, at least 4.
- ADDR_WIDTH, 10, log2(DEPTH).

Ports:
- clock, input, 1, single clock for the whole block.
- reset_n, input, 1, asynchronous active-low reset.
- dac_data, input, 16*NUMBER_OF_LINE, DAC word sampled every cycle.
- arm, input, 1, single-cycle request to arm; honoured only in IDLE.
- trigger, input, 1, starts capture; honoured only in ARMED.
- abort, input, 1, synchronous return to IDLE from any state.
- capture_length, input, ADDR_WIDTH+1, number of words to capture; latched on an accepted arm.
- m_tdata, output, 16*NUMBER_OF_LINE, replay data.
- m_tvalid, output, 1, replay data valid.
- m_tready, input, 1, downstream ready.
- m_tlast, output, 1, marks the final replay word.
- busy, output, 1, high whenever the state is not IDLE.
- done, output, 1, one-cycle pulse after the final replay handshake.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - m_tvalid, m_tlast, busy, done, write/read pointers and the latched length are all 0.
  - m_tdata is 0.
  - RAM contents are not reset.
- Length latching at arm:
  - A value of 0, or any value greater than DEPTH, latches as DEPTH.
  - Any other value latches as given (1..DEPTH).
- States: IDLE, ARMED, CAPTURE, READOUT.
- IDLE -> ARMED: on arm=1.
- ARMED -> CAPTURE: on trigger=1.
  - The dac_data present in the trigger cycle is written to address 0.
  - Every following cycle writes one word, with no gaps.
- CAPTURE: the write address increments by 1 per cycle. The write at address L-1 (L = latched length) is the last; the next cycle enters READOUT.
  - If trigger and arm occur together in ARMED, trigger wins and arm is ignored.
  - Trigger pulses during CAPTURE or READOUT are ignored.
- READOUT:
  - Words are replayed from address 0 to L-1 in order.
  - RAM read latency is 1 cycle. If the last write happens in cycle T, m_tvalid first rises in cycle T+2 with the address-0 word.
  - With m_tready held high, one word transfers per cycle with no bubbles. This needs a read-ahead/skid arrangement; the RAM read enable is (!m_tvalid || m_tready).
  - AXI rules:
    - Once m_tvalid is asserted, m_tdata and m_tlast stay stable until m_tready.
    - m_tvalid never depends combinationally on m_tready.
  - m_tlast=1 only with word L-1.
  - On the m_tlast handshake: the next cycle has state IDLE, m_tvalid=0, busy=0, and done=1 for exactly one cycle.
- abort:
  - Takes priority over every other input.
  - Next cycle: state IDLE, m_tvalid=0, m_tlast=0, pointers cleared, done stays 0.
  - Takes effect mid-capture and mid-replay alike.
- arm while busy: ignored; the latched length is unchanged.
- L=1:
  - Capture occupies only the trigger cycle.
  - The single replay word carries m_tlast=1.
- Pointer wrap: pointers stop at L-1; no wrap-around occurs even when L=DEPTH.
- Timing: dac_data is registered before the RAM write, so the write path sees only a register-to-RAM path; this adds no visible latency beyond that stated above.

Test Plan:
- Length 8, ramp on dac_data:
  - Stimulus: capture_length=8, arm at cycle 0, trigger at cycle 5 with lane0=value k at cycle k, m_tready=1.
  - Expect: replay lane0 = 5,6,...,12 on consecutive cycles; m_tvalid rises 2 cycles after the write of value 12; m_tlast on 12; done pulses once.
- Backpressure:
  - Stimulus: length 16, m_tready toggling 1,0,0,1 repeatedly.
  - Expect: all 16 words delivered in order, no duplicates or drops, m_tdata stable while stalled.
- Length clamping:
  - Stimulus: capture_length=0, then 2000 in a later run.
  - Expect: exactly 1024 words each time; m_tlast on word 1023.
- Ignored controls:
  - Stimulus: trigger before arm; arm during READOUT; second trigger during CAPTURE.
  - Expect: state unchanged by all three; replay length and contents unchanged.
- Abort:
  - Stimulus: abort at capture word 3, then abort again at replay word 2 of a fresh run.
  - Expect: the next cycle shows busy=0, m_tvalid=0, done=0 each time; a following arm/trigger run completes normally.
- Async reset:
  - Stimulus: reset_n low mid-READOUT, asserted between clock edges.
  - Expect: m_tvalid, busy, and done go to 0 immediately, without waiting for a clock edge; after release, the block is in IDLE and accepts a new arm.

Source files
------------

// File: rtl/dac_snapshot_capture.sv
// Debug snapshot of a multi-lane DAC bus: arm, trigger, capture a burst into RAM,
// then replay it over an AXI-Stream-style master port.
module dac_snapshot_capture #(
  parameter int NUMBER_OF_LINE = 8,
  parameter int DEPTH          = 1024,
  parameter int ADDR_WIDTH     = 10
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [16*NUMBER_OF_LINE-1:0]  dac_data,
  input  logic                          arm,
  input  logic                          trigger,
  input  logic                          abort,
  input  logic [ADDR_WIDTH:0]           capture_length,
  output logic [16*NUMBER_OF_LINE-1:0]  m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    state_dbg
);

  // Stream handshake: a word transfers on a clock edge where m_tvalid and m_tready
  // are both high; once m_tvalid is up, m_tdata/m_tlast hold until that transfer,
  // and m_tvalid is purely registered (no combinational path from m_tready).

  localparam int DATA_WIDTH = 16 * NUMBER_OF_LINE;
  localparam logic [ADDR_WIDTH:0] DEPTH_LEN = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] dac_q;
  logic                  wr_pend;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_done;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic                  capture_en;
  logic                  wr_last;
  logic                  rd_last;
  logic                  read_en;
  logic                  last_hs;

  assign last_addr = ADDR_WIDTH'(len_q - (ADDR_WIDTH+1)'(1));
  assign wr_last   = (wr_ptr == last_addr);
  assign rd_last   = (rd_ptr == last_addr);
  assign read_en   = !m_tvalid || m_tready;
  assign last_hs   = m_tvalid && m_tready && m_tlast;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture_en = 1'b0;
    case (state)
      S_IDLE:    if (arm) state_next = S_ARMED;
      S_ARMED: begin
        if (trigger) begin
          capture_en = 1'b1;
          state_next = wr_last ? S_READOUT : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        capture_en = 1'b1;
        if (wr_last) state_next = S_READOUT;
      end
      S_READOUT: if (last_hs) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    if (abort) begin
      state_next = S_IDLE;
      capture_en = 1'b0;
    end
  end

  // Input register and RAM write port; the write lands one cycle after the sample.
  always_ff @(posedge clock) begin
    dac_q <= dac_data;
    if (wr_pend) mem[wr_addr_q] <= dac_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_pend   <= 1'b0;
      wr_addr_q <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_done   <= 1'b0;
      len_q     <= '0;
      m_tdata   <= '0;
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      wr_pend  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_done  <= 1'b0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done      <= 1'b0;
      wr_pend   <= capture_en;
      wr_addr_q <= wr_ptr;
      if (state == S_IDLE && arm) begin
        if (capture_length == '0 || capture_length > DEPTH_LEN) len_q <= DEPTH_LEN;
        else                                                    len_q <= capture_length;
      end
      if (capture_en && !wr_last) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (state == S_READOUT) begin
        if (last_hs) begin
          m_tvalid <= 1'b0;
          m_tlast  <= 1'b0;
          done     <= 1'b1;
          wr_ptr   <= '0;
          rd_ptr   <= '0;
          rd_done  <= 1'b0;
        end else if (read_en) begin
          // The output register doubles as the RAM read register; the final write
          // can coincide with the first read when only one word was captured.
          if (!rd_done) begin
            m_tdata  <= (wr_pend && wr_addr_q == rd_ptr) ? dac_q : mem[rd_ptr];
            m_tvalid <= 1'b1;
            m_tlast  <= rd_last;
            if (rd_last) rd_done <= 1'b1;
            else         rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
          end else begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_snapshot_capture.sv
// Directed/randomized bench for dac_snapshot_capture: a queue of the words presented
// during capture is the expected replay stream.
module tb_dac_snapshot_capture;

  localparam int NL    = 8;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int DW    = 16 * NL;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [DW-1:0] dac_data;
  logic          arm, trigger, abort;
  logic [AW:0]   capture_length;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic          busy, done;
  logic [1:0]    state_dbg;

  dac_snapshot_capture #(.NUMBER_OF_LINE(NL), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .dac_data(dac_data),
    .arm(arm), .trigger(trigger), .abort(abort), .capture_length(capture_length),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  int            n_asserts = 0;
  int            n_fail    = 0;
  int            cyc       = 0;
  bit            ramp_mode = 1'b0;
  logic [DW-1:0] exp_q[$];

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic new_word();
    if (ramp_mode) dac_data = DW'(cyc);
    else           dac_data = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick_ready(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4 == 0) || (k % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One arm/trigger/capture/replay run; negative abort_cap/abort_rep/reset_rep disable those events.
  task automatic run(input int len_in, input int exp_len, input int mode, input int abort_cap,
                     input int abort_rep, input int reset_rep, input bit disturb);
    int            budget, k, n_rx;
    logic          rdy, stalled, hs, was_last, held_last;
    logic [DW-1:0] held_data, exp_w;
    capture_length = (AW+1)'(len_in);
    arm = 1'b1;
    new_word();
    step();
    arm = 1'b0;
    check("arm_busy", busy, 1);
    check("arm_state", state_dbg, ST_ARMED);
    repeat (4) begin new_word(); step(); end
    check("armed_hold", state_dbg, ST_ARMED);
    exp_q.delete();
    for (int i = 0; i < exp_len; i++) begin
      new_word();
      trigger = (i == 0) || (disturb && i == 2);
      if (disturb && i == 0) begin arm = 1'b1; capture_length = 3; end
      abort = (i == abort_cap);
      exp_q.push_back(dac_data);
      step();
      trigger = 1'b0;
      arm     = 1'b0;
      if (i == abort_cap) begin
        abort = 1'b0;
        check("abort_cap_busy", busy, 0);
        check("abort_cap_valid", m_tvalid, 0);
        check("abort_cap_done", done, 0);
        check("abort_cap_state", state_dbg, ST_IDLE);
        step();
        check("abort_cap_done2", done, 0);
        return;
      end
      check("cap_valid", m_tvalid, 0);
    end
    check("t1_valid", m_tvalid, 0);
    check("t1_busy", busy, 1);
    m_tready = 1'b0;
    new_word();
    step();
    check("t2_valid", m_tvalid, 1);
    stalled = 1'b0; held_last = 1'b0; held_data = '0;
    n_rx = 0; k = 0;
    budget = 4 * exp_len + 20;
    while (budget > 0) begin
      budget--;
      if (stalled) begin
        check("stall_data", m_tdata, held_data);
        check("stall_last", m_tlast, held_last);
      end
      if (n_rx == reset_rep && m_tvalid) begin
        m_tready = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_valid", m_tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tdata", m_tdata, 0);
        step();
        reset_n = 1'b1;
        step();
        check("rst_state", state_dbg, ST_IDLE);
        return;
      end
      if (n_rx == abort_rep && m_tvalid) begin
        abort    = 1'b1;
        m_tready = 1'b0;
        step();
        abort = 1'b0;
        check("abort_rep_busy", busy, 0);
        check("abort_rep_valid", m_tvalid, 0);
        check("abort_rep_last", m_tlast, 0);
        check("abort_rep_done", done, 0);
        step();
        check("abort_rep_done2", done, 0);
        return;
      end
      rdy = pick_ready(mode, k);
      k++;
      m_tready = rdy;
      if (disturb && n_rx == 2) begin arm = 1'b1; capture_length = 5; end
      hs = m_tvalid && rdy;
      was_last = 1'b0;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          exp_w = exp_q.pop_front();
          check("data", m_tdata, exp_w);
          check("tlast", m_tlast, exp_q.size() == 0);
          was_last = (exp_q.size() == 0);
        end
        n_rx++;
      end
      stalled   = m_tvalid && !rdy;
      held_data = m_tdata;
      held_last = m_tlast;
      new_word();
      step();
      arm = 1'b0;
      if (was_last) begin
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_valid", m_tvalid, 0);
        check("end_state", state_dbg, ST_IDLE);
        m_tready = 1'b0;
        step();
        check("end_done_pulse", done, 0);
        return;
      end
    end
    check("readout_timeout", 0, 1);
    m_tready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; arm = 1'b0; trigger = 1'b0; abort = 1'b0;
    m_tready = 1'b0; capture_length = '0; dac_data = '0;
    step();
    step();
    check("reset_tdata", m_tdata, 0);
    check("reset_tvalid", m_tvalid, 0);
    check("reset_tlast", m_tlast, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset_n = 1'b1;
    step();
    check("post_reset_state", state_dbg, ST_IDLE);

    // Trigger with nothing armed must be ignored.
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    check("early_trig_busy", busy, 0);
    check("early_trig_state", state_dbg, ST_IDLE);

    ramp_mode = 1'b1;
    cyc = 0;
    run(8, 8, 0, -1, -1, -1, 1'b0);
    ramp_mode = 1'b0;
    run(16, 16, 1, -1, -1, -1, 1'b0);
    run(0, DEPTH, 0, -1, -1, -1, 1'b0);
    run(2000, DEPTH, 2, -1, -1, -1, 1'b0);
    run(1, 1, 0, -1, -1, -1, 1'b0);
    run(1, 1, 1, -1, -1, -1, 1'b0);
    run(12, 12, 2, -1, -1, -1, 1'b1);
    run(10, 10, 0, 3, -1, -1, 1'b0);
    run(10, 10, 0, -1, 2, -1, 1'b0);
    run(6, 6, 1, -1, -1, -1, 1'b0);
    run(20, 20, 1, -1, -1, 3, 1'b0);
    run(5, 5, 2, -1, -1, -1, 1'b0);
    for (int r = 0; r < 3; r++) begin
      int len;
      len = int'($urandom_range(1, 40));
      run(len, len, int'($urandom_range(0, 2)), -1, -1, -1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
